// File: rtl/alu_pkg.sv
// alu_pkg: opcode, FSM state and handshake encodings for alu_pipe_v2.
// Also provides the rotate shift-width helper.
package alu_pkg;

  typedef enum logic [3:0] {
    A_ADD,
    A_SUB,
    A_ADD_CIN,
    A_SUB_CIN,
    A_INC_A,
    A_DEC_A,
    A_INC_B,
    A_DEC_B,
    A_CMP,
    A_MUL_INC,
    A_MUL_SHL,
    A_SADD,
    A_SSUB
  } arith_cmd_e;

  typedef enum logic [3:0] {
    L_AND,
    L_NAND,
    L_OR,
    L_NOR,
    L_XOR,
    L_XNOR,
    L_NOT_A,
    L_NOT_B,
    L_SHR_A,
    L_SHL_A,
    L_SHR_B,
    L_SHL_B,
    L_ROL,
    L_ROR
  } logic_cmd_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_A,
    S_WAIT_B,
    S_MUL1,
    S_MUL2
  } state_e;

  localparam logic [1:0] IV_NONE = 2'b00;
  localparam logic [1:0] IV_A    = 2'b01;
  localparam logic [1:0] IV_B    = 2'b10;
  localparam logic [1:0] IV_AB   = 2'b11;

  function automatic int sw_of(input int dw);
    return $clog2(dw);
  endfunction

endpackage

// File: rtl/alu_mul_pipe.sv
// alu_mul_pipe: two registered stages, operands then full-width product.
// A valid bit shifts alongside the data so the lane knows when it lands.
module alu_mul_pipe #(
  parameter int DW = 8
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            ce,
  input  logic            req,
  input  logic [DW-1:0]   mul_a,
  input  logic [DW-1:0]   mul_b,
  output logic            done,
  output logic [2*DW-1:0] prod
);

  logic [DW-1:0] a_q;
  logic [DW-1:0] b_q;
  logic          v1_q;

  // stage 1: capture the pre-processed operands
  always_ff @(posedge CLK) begin
    if (!RST) begin
      a_q  <= '0;
      b_q  <= '0;
      v1_q <= 1'b0;
    end else if (ce) begin
      v1_q <= req;
      if (req) begin
        a_q <= mul_a;
        b_q <= mul_b;
      end
    end
  end

  // stage 2: register the double-width product
  always_ff @(posedge CLK) begin
    if (!RST) begin
      prod <= '0;
      done <= 1'b0;
    end else if (ce) begin
      done <= v1_q;
      if (v1_q) begin
        prod <= {{DW{1'b0}}, a_q} * {{DW{1'b0}}, b_q};
      end
    end
  end

endmodule

// File: rtl/alu_pipe_v2.sv
// alu_pipe_v2: split-operand ALU lane, operand timeout, pipelined multiply.
// Define ALU_SIGNED_OPS_EN to enable signed add/sub (CMD 11/12).
module alu_pipe_v2
  import alu_pkg::*;
#(
  parameter int DW      = 8,
  parameter int CW      = 4,
  parameter int TIMEOUT = 16
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            CE,
  input  logic            MODE,
  input  logic [CW-1:0]   CMD,
  input  logic [1:0]      INP_VALID,
  input  logic [DW-1:0]   OPA,
  input  logic [DW-1:0]   OPB,
  input  logic            CIN,
  output logic [2*DW-1:0] RES,
  output logic            RES_VALID,
  output logic            COUT,
  output logic            OFLOW,
  output logic            G,
  output logic            E,
  output logic            L,
  output logic            ERR,
  output logic            BUSY
);

  localparam int SW = sw_of(DW);
  localparam int TW = $clog2(TIMEOUT + 1);

  state_e        state_q, state_n;
  logic [TW-1:0] cnt_q, cnt_n;
  logic [DW-1:0] a_q, a_n;
  logic [DW-1:0] b_q, b_n;
  logic          issue, tmo;

  logic [3:0]    op;
  logic          cmd_hi;
  logic          is_mul;
  logic [DW-1:0] op_a, op_b;
  logic [DW-1:0] mul_a, mul_b;
  logic          mul_done;
  logic [2*DW-1:0] prod;

  logic [DW:0]   sum, sumc, bcin;
  logic [DW:0]   a_inc, b_inc;
  logic [DW-1:0] diff, diffc;
  logic [SW-1:0] sh;
  logic          rng_err;
`ifdef ALU_SIGNED_OPS_EN
  logic [DW:0]   ssum, sdif;
`endif

  logic [DW:0]     lo;
  logic            sext;
  logic [2*DW-1:0] res_c;
  logic            cout_c, oflow_c;
  logic            g_c, e_c, l_c, err_c;

  assign op     = 4'(CMD);
  assign cmd_hi = (CMD >> 4) != '0;
  assign is_mul = MODE && !cmd_hi &&
                  (op == A_MUL_INC || op == A_MUL_SHL);

  assign op_a = INP_VALID[0] ? OPA : a_q;
  assign op_b = INP_VALID[1] ? OPB : b_q;

  assign mul_a = (op == A_MUL_INC) ? op_a + 1'b1 : op_a << 1;
  assign mul_b = (op == A_MUL_INC) ? op_b + 1'b1 : op_b;

  assign sum   = {1'b0, op_a} + {1'b0, op_b};
  assign sumc  = sum + {{DW{1'b0}}, CIN};
  assign bcin  = {1'b0, op_b} + {{DW{1'b0}}, CIN};
  assign a_inc = {1'b0, op_a} + 1'b1;
  assign b_inc = {1'b0, op_b} + 1'b1;
  assign diff  = op_a - op_b;
  assign diffc = diff - {{(DW-1){1'b0}}, CIN};
  assign sh    = op_b[SW-1:0];
  assign rng_err = |(op_b >> SW);
`ifdef ALU_SIGNED_OPS_EN
  assign ssum = {op_a[DW-1], op_a} + {op_b[DW-1], op_b};
  assign sdif = {op_a[DW-1], op_a} - {op_b[DW-1], op_b};
`endif

  function automatic logic [DW-1:0] rotl(
    input logic [DW-1:0] v,
    input logic [SW-1:0] s
  );
    logic [2*DW-1:0] w;
    w = {v, v} << s;
    return w[2*DW-1:DW];
  endfunction

  function automatic logic [DW-1:0] rotr(
    input logic [DW-1:0] v,
    input logic [SW-1:0] s
  );
    logic [2*DW-1:0] w;
    w = {v, v} >> s;
    return w[DW-1:0];
  endfunction

  // operand handshake, timeout and multiply sequencing
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    a_n     = a_q;
    b_n     = b_q;
    issue   = 1'b0;
    tmo     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        unique case (INP_VALID)
          IV_AB: issue = 1'b1;
          IV_A: begin
            a_n     = OPA;
            cnt_n   = '0;
            state_n = S_WAIT_B;
          end
          IV_B: begin
            b_n     = OPB;
            cnt_n   = '0;
            state_n = S_WAIT_A;
          end
          default: ;
        endcase
      end
      S_WAIT_B: begin
        if (INP_VALID[1]) begin
          issue = 1'b1;
        end else if (INP_VALID == IV_A) begin
          a_n   = OPA;
          cnt_n = '0;
        end else if (cnt_q == TW'(TIMEOUT)) begin
          tmo = 1'b1;
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end
      S_WAIT_A: begin
        if (INP_VALID[0]) begin
          issue = 1'b1;
        end else if (INP_VALID == IV_B) begin
          b_n   = OPB;
          cnt_n = '0;
        end else if (cnt_q == TW'(TIMEOUT)) begin
          tmo = 1'b1;
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end
      S_MUL1:  state_n = S_MUL2;
      S_MUL2:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    if (issue || tmo) begin
      state_n = (issue && is_mul) ? S_MUL1 : S_IDLE;
      cnt_n   = '0;
      a_n     = '0;
      b_n     = '0;
    end
  end

  // single-cycle result and flags for the completing beat
  always_comb begin
    lo      = '0;
    sext    = 1'b0;
    cout_c  = 1'b0;
    oflow_c = 1'b0;
    g_c     = 1'b0;
    e_c     = 1'b0;
    l_c     = 1'b0;
    err_c   = 1'b0;
    if (cmd_hi) begin
      err_c = 1'b1;
    end else if (MODE) begin
      unique case (op)
        A_ADD: begin
          lo     = sum;
          cout_c = sum[DW];
        end
        A_SUB: begin
          lo      = {1'b0, diff};
          oflow_c = op_a < op_b;
        end
        A_ADD_CIN: begin
          lo     = sumc;
          cout_c = sumc[DW];
        end
        A_SUB_CIN: begin
          lo      = {1'b0, diffc};
          oflow_c = {1'b0, op_a} < bcin;
        end
        A_INC_A: lo = a_inc;
        A_DEC_A: lo = {1'b0, op_a - 1'b1};
        A_INC_B: lo = b_inc;
        A_DEC_B: lo = {1'b0, op_b - 1'b1};
        A_CMP: begin
          g_c = op_a > op_b;
          e_c = op_a == op_b;
          l_c = op_a < op_b;
        end
        A_MUL_INC, A_MUL_SHL: lo = '0;
`ifdef ALU_SIGNED_OPS_EN
        A_SADD: begin
          lo      = ssum;
          sext    = 1'b1;
          oflow_c = ssum[DW] ^ ssum[DW-1];
        end
        A_SSUB: begin
          lo      = sdif;
          sext    = 1'b1;
          oflow_c = sdif[DW] ^ sdif[DW-1];
        end
`endif
        default: err_c = 1'b1;
      endcase
    end else begin
      unique case (op)
        L_AND:   lo = {1'b0, op_a & op_b};
        L_NAND:  lo = {1'b0, ~(op_a & op_b)};
        L_OR:    lo = {1'b0, op_a | op_b};
        L_NOR:   lo = {1'b0, ~(op_a | op_b)};
        L_XOR:   lo = {1'b0, op_a ^ op_b};
        L_XNOR:  lo = {1'b0, ~(op_a ^ op_b)};
        L_NOT_A: lo = {1'b0, ~op_a};
        L_NOT_B: lo = {1'b0, ~op_b};
        L_SHR_A: lo = {1'b0, op_a >> 1};
        L_SHL_A: lo = {1'b0, op_a << 1};
        L_SHR_B: lo = {1'b0, op_b >> 1};
        L_SHL_B: lo = {1'b0, op_b << 1};
        L_ROL: begin
          lo    = {1'b0, rotl(op_a, sh)};
          err_c = rng_err;
        end
        L_ROR: begin
          lo    = {1'b0, rotr(op_a, sh)};
          err_c = rng_err;
        end
        default: err_c = 1'b1;
      endcase
    end
    res_c = sext ? {{(DW-1){lo[DW]}}, lo}
                 : {{(DW-1){1'b0}}, lo};
  end

  alu_mul_pipe #(
    .DW(DW)
  ) u_mul (
    .CLK   (CLK),
    .RST   (RST),
    .ce    (CE),
    .req   (issue && is_mul),
    .mul_a (mul_a),
    .mul_b (mul_b),
    .done  (mul_done),
    .prod  (prod)
  );

  // FSM state, timeout counter and held operands
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else if (CE) begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      a_q     <= a_n;
      b_q     <= b_n;
    end
  end

  // registered outputs; flags clear on every strobe unless the op sets them
  always_ff @(posedge CLK) begin
    if (!RST) begin
      RES       <= '0;
      RES_VALID <= 1'b0;
      COUT      <= 1'b0;
      OFLOW     <= 1'b0;
      G         <= 1'b0;
      E         <= 1'b0;
      L         <= 1'b0;
      ERR       <= 1'b0;
      BUSY      <= 1'b0;
    end else if (CE) begin
      RES_VALID <= 1'b0;
      BUSY      <= (state_n == S_MUL1) || (state_n == S_MUL2);
      if (mul_done) begin
        RES       <= prod;
        RES_VALID <= 1'b1;
        {COUT, OFLOW, G, E, L, ERR} <= '0;
      end else if (issue && !is_mul) begin
        RES       <= res_c;
        RES_VALID <= 1'b1;
        COUT      <= cout_c;
        OFLOW     <= oflow_c;
        G         <= g_c;
        E         <= e_c;
        L         <= l_c;
        ERR       <= err_c;
      end else if (tmo) begin
        RES       <= '0;
        RES_VALID <= 1'b1;
        {COUT, OFLOW, G, E, L} <= '0;
        ERR       <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe_v2.sv
// tb_alu_pipe_v2: directed-vector bench for alu_pipe_v2 (DW=8, TIMEOUT=16).
// Build with ALU_SIGNED_OPS_EN defined to cover the signed opcodes.
module tb_alu_pipe_v2;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        CE = 1'b1;
  logic        MODE = 1'b0;
  logic [3:0]  CMD = '0;
  logic [1:0]  INP_VALID = '0;
  logic [7:0]  OPA = '0;
  logic [7:0]  OPB = '0;
  logic        CIN = 1'b0;
  logic [15:0] RES;
  logic        RES_VALID, COUT, OFLOW, G, E, L, ERR, BUSY;

  int nvec = 0;
  int nbad = 0;

  typedef struct packed {
    logic        m;
    logic [3:0]  c;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        ci;
    logic [15:0] r;
    logic [5:0]  f;
  } vec_t;

  always #5 CLK = ~CLK;

  alu_pipe_v2 #(
    .DW(8),
    .CW(4),
    .TIMEOUT(16)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .CE        (CE),
    .MODE      (MODE),
    .CMD       (CMD),
    .INP_VALID (INP_VALID),
    .OPA       (OPA),
    .OPB       (OPB),
    .CIN       (CIN),
    .RES       (RES),
    .RES_VALID (RES_VALID),
    .COUT      (COUT),
    .OFLOW     (OFLOW),
    .G         (G),
    .E         (E),
    .L         (L),
    .ERR       (ERR),
    .BUSY      (BUSY)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic beat(
    input logic [1:0] iv,
    input logic       m,
    input logic [3:0] c,
    input logic [7:0] a,
    input logic [7:0] b,
    input logic       ci
  );
    INP_VALID = iv;
    MODE      = m;
    CMD       = c;
    OPA       = a;
    OPB       = b;
    CIN       = ci;
    step();
    INP_VALID = 2'b00;
  endtask

  task automatic test_reset();
    RST = 1'b0;
    step();
    step();
    nvec++;
    if ({RES, RES_VALID, COUT, OFLOW, G, E, L, ERR, BUSY} !== 24'h0) begin
      nbad++;
      $display("FAIL reset: got res=%h v=%b err=%b busy=%b want all 0",
               RES, RES_VALID, ERR, BUSY);
    end
    RST = 1'b1;
    step();
  endtask

  task automatic test_add_carry();
    beat(2'b11, 1'b1, 4'd0, 8'hFF, 8'h01, 1'b0);
    nvec++;
    if ({RES_VALID, COUT, ERR, RES} !== {3'b110, 16'h0100}) begin
      nbad++;
      $display("FAIL add_carry: got v=%b c=%b e=%b res=%h want 1 1 0 0100",
               RES_VALID, COUT, ERR, RES);
    end
    step();
    nvec++;
    if ({RES_VALID, RES} !== {1'b0, 16'h0100}) begin
      nbad++;
      $display("FAIL add_hold: got v=%b res=%h want 0 0100",
               RES_VALID, RES);
    end
  endtask

  task automatic test_split();
    beat(2'b01, 1'b1, 4'd0, 8'h05, 8'h00, 1'b0);
    repeat (6) step();
    nvec++;
    if (RES_VALID !== 1'b0) begin
      nbad++;
      $display("FAIL split_wait: got v=%b want 0", RES_VALID);
    end
    beat(2'b10, 1'b1, 4'd1, 8'h00, 8'h07, 1'b0);
    nvec++;
    if ({RES_VALID, OFLOW, ERR, RES} !== {3'b110, 16'h00FE}) begin
      nbad++;
      $display("FAIL split_sub: got v=%b o=%b e=%b res=%h want 1 1 0 00fe",
               RES_VALID, OFLOW, ERR, RES);
    end
  endtask

  task automatic test_timeout();
    beat(2'b01, 1'b1, 4'd0, 8'h10, 8'h00, 1'b0);
    for (int i = 0; i < 16; i++) begin
      step();
      nvec++;
      if (RES_VALID !== 1'b0) begin
        nbad++;
        $display("FAIL tmo_early: idle %0d got v=%b want 0", i, RES_VALID);
      end
    end
    step();
    nvec++;
    if ({RES_VALID, ERR, RES} !== {2'b11, 16'h0000}) begin
      nbad++;
      $display("FAIL tmo_fire: got v=%b e=%b res=%h want 1 1 0000",
               RES_VALID, ERR, RES);
    end
    beat(2'b11, 1'b1, 4'd1, 8'h09, 8'h03, 1'b0);
    nvec++;
    if ({RES_VALID, ERR, RES} !== {2'b10, 16'h0006}) begin
      nbad++;
      $display("FAIL tmo_after: got v=%b e=%b res=%h want 1 0 0006",
               RES_VALID, ERR, RES);
    end
    beat(2'b01, 1'b1, 4'd0, 8'h22, 8'h00, 1'b0);
    repeat (16) step();
    beat(2'b10, 1'b1, 4'd0, 8'h00, 8'h11, 1'b0);
    nvec++;
    if ({RES_VALID, ERR, RES} !== {2'b10, 16'h0033}) begin
      nbad++;
      $display("FAIL tmo_race: got v=%b e=%b res=%h want 1 0 0033",
               RES_VALID, ERR, RES);
    end
  endtask

  task automatic test_mul();
    beat(2'b11, 1'b1, 4'd9, 8'd3, 8'd4, 1'b0);
    nvec++;
    if ({BUSY, RES_VALID} !== 2'b10) begin
      nbad++;
      $display("FAIL mul_c1: got busy=%b v=%b want 1 0", BUSY, RES_VALID);
    end
    INP_VALID = 2'b11;
    CMD       = 4'd0;
    OPA       = 8'h01;
    OPB       = 8'h01;
    step();
    nvec++;
    if ({BUSY, RES_VALID} !== 2'b10) begin
      nbad++;
      $display("FAIL mul_c2: got busy=%b v=%b want 1 0", BUSY, RES_VALID);
    end
    step();
    INP_VALID = 2'b00;
    nvec++;
    if ({BUSY, RES_VALID, ERR, RES} !== {3'b010, 16'd20}) begin
      nbad++;
      $display("FAIL mul_res: got busy=%b v=%b e=%b res=%h want 0 1 0 0014",
               BUSY, RES_VALID, ERR, RES);
    end
    step();
    nvec++;
    if ({RES_VALID, RES} !== {1'b0, 16'd20}) begin
      nbad++;
      $display("FAIL mul_ignored: got v=%b res=%h want 0 0014",
               RES_VALID, RES);
    end
    beat(2'b11, 1'b1, 4'd9, 8'hFE, 8'hFE, 1'b0);
    step();
    step();
    nvec++;
    if ({RES_VALID, RES} !== {1'b1, 16'hFE01}) begin
      nbad++;
      $display("FAIL mul_inc_big: got v=%b res=%h want 1 fe01",
               RES_VALID, RES);
    end
    beat(2'b11, 1'b1, 4'd10, 8'h81, 8'h03, 1'b0);
    step();
    step();
    nvec++;
    if ({RES_VALID, RES} !== {1'b1, 16'h0006}) begin
      nbad++;
      $display("FAIL mul_shl: got v=%b res=%h want 1 0006",
               RES_VALID, RES);
    end
  endtask

  task automatic test_ops();
    vec_t tv[$];
    tv.push_back({1'b1, 4'd2,  8'h7F, 8'h80, 1'b1, 16'h0100, 6'b010000});
    tv.push_back({1'b1, 4'd3,  8'h05, 8'h05, 1'b1, 16'h00FF, 6'b001000});
    tv.push_back({1'b1, 4'd3,  8'h09, 8'h03, 1'b1, 16'h0005, 6'b000000});
    tv.push_back({1'b1, 4'd4,  8'hFF, 8'h00, 1'b0, 16'h0100, 6'b000000});
    tv.push_back({1'b1, 4'd5,  8'h00, 8'h00, 1'b0, 16'h00FF, 6'b000000});
    tv.push_back({1'b1, 4'd6,  8'h00, 8'h41, 1'b0, 16'h0042, 6'b000000});
    tv.push_back({1'b1, 4'd7,  8'h00, 8'h00, 1'b0, 16'h00FF, 6'b000000});
    tv.push_back({1'b1, 4'd8,  8'h03, 8'h05, 1'b0, 16'h0000, 6'b000001});
    tv.push_back({1'b1, 4'd8,  8'h05, 8'h05, 1'b0, 16'h0000, 6'b000010});
    tv.push_back({1'b1, 4'd8,  8'h09, 8'h05, 1'b0, 16'h0000, 6'b000100});
    tv.push_back({1'b1, 4'd0,  8'h10, 8'h20, 1'b0, 16'h0030, 6'b000000});
    tv.push_back({1'b1, 4'd13, 8'h10, 8'h20, 1'b0, 16'h0000, 6'b100000});
    tv.push_back({1'b1, 4'd15, 8'h10, 8'h20, 1'b0, 16'h0000, 6'b100000});
`ifdef ALU_SIGNED_OPS_EN
    tv.push_back({1'b1, 4'd11, 8'h7F, 8'h01, 1'b0, 16'h0080, 6'b001000});
    tv.push_back({1'b1, 4'd12, 8'h80, 8'h01, 1'b0, 16'hFF7F, 6'b001000});
    tv.push_back({1'b1, 4'd11, 8'hFE, 8'h01, 1'b0, 16'hFFFF, 6'b000000});
`else
    tv.push_back({1'b1, 4'd11, 8'h7F, 8'h01, 1'b0, 16'h0000, 6'b100000});
    tv.push_back({1'b1, 4'd12, 8'h80, 8'h01, 1'b0, 16'h0000, 6'b100000});
`endif
    tv.push_back({1'b0, 4'd0,  8'hF0, 8'h3C, 1'b0, 16'h0030, 6'b000000});
    tv.push_back({1'b0, 4'd1,  8'hF0, 8'h3C, 1'b0, 16'h00CF, 6'b000000});
    tv.push_back({1'b0, 4'd2,  8'hF0, 8'h0F, 1'b0, 16'h00FF, 6'b000000});
    tv.push_back({1'b0, 4'd3,  8'hF0, 8'h0F, 1'b0, 16'h0000, 6'b000000});
    tv.push_back({1'b0, 4'd4,  8'hFF, 8'h0F, 1'b0, 16'h00F0, 6'b000000});
    tv.push_back({1'b0, 4'd5,  8'hFF, 8'h0F, 1'b0, 16'h000F, 6'b000000});
    tv.push_back({1'b0, 4'd6,  8'h5A, 8'h00, 1'b0, 16'h00A5, 6'b000000});
    tv.push_back({1'b0, 4'd7,  8'h00, 8'h00, 1'b0, 16'h00FF, 6'b000000});
    tv.push_back({1'b0, 4'd8,  8'h81, 8'h00, 1'b0, 16'h0040, 6'b000000});
    tv.push_back({1'b0, 4'd9,  8'h81, 8'h00, 1'b0, 16'h0002, 6'b000000});
    tv.push_back({1'b0, 4'd10, 8'h00, 8'h03, 1'b0, 16'h0001, 6'b000000});
    tv.push_back({1'b0, 4'd11, 8'h00, 8'hC0, 1'b0, 16'h0080, 6'b000000});
    tv.push_back({1'b0, 4'd12, 8'h81, 8'h11, 1'b0, 16'h0003, 6'b100000});
    tv.push_back({1'b0, 4'd12, 8'h81, 8'h02, 1'b0, 16'h0006, 6'b000000});
    tv.push_back({1'b0, 4'd13, 8'h81, 8'h01, 1'b0, 16'h00C0, 6'b000000});
    tv.push_back({1'b0, 4'd13, 8'h01, 8'h08, 1'b0, 16'h0001, 6'b100000});
    tv.push_back({1'b0, 4'd14, 8'h81, 8'h01, 1'b0, 16'h0000, 6'b100000});
    tv.push_back({1'b0, 4'd15, 8'h81, 8'h01, 1'b0, 16'h0000, 6'b100000});
    foreach (tv[i]) begin
      beat(2'b11, tv[i].m, tv[i].c, tv[i].a, tv[i].b, tv[i].ci);
      nvec++;
      if ({RES_VALID, RES, ERR, COUT, OFLOW, G, E, L}
          !== {1'b1, tv[i].r, tv[i].f}) begin
        nbad++;
        $display("FAIL op m%0d c%0d: got v=%b res=%h f=%b want 1 %h %b",
                 tv[i].m, tv[i].c, RES_VALID, RES,
                 {ERR, COUT, OFLOW, G, E, L}, tv[i].r, tv[i].f);
      end
    end
    step();
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 3; i++) begin
      beat(2'b11, 1'b1, 4'd0, 8'(i), 8'(i), 1'b0);
      nvec++;
      if ({RES_VALID, RES} !== {1'b1, 16'(2 * i)}) begin
        nbad++;
        $display("FAIL b2b_%0d: got v=%b res=%h want 1 %h",
                 i, RES_VALID, RES, 16'(2 * i));
      end
    end
    step();
    nvec++;
    if (RES_VALID !== 1'b0) begin
      nbad++;
      $display("FAIL b2b_end: got v=%b want 0", RES_VALID);
    end
  endtask

  task automatic test_ce();
    CE = 1'b0;
    beat(2'b11, 1'b1, 4'd0, 8'h05, 8'h05, 1'b0);
    nvec++;
    if ({RES_VALID, RES} !== {1'b0, 16'h0006}) begin
      nbad++;
      $display("FAIL ce_beat: got v=%b res=%h want 0 0006",
               RES_VALID, RES);
    end
    CE = 1'b1;
    beat(2'b01, 1'b1, 4'd0, 8'h10, 8'h00, 1'b0);
    CE = 1'b0;
    repeat (30) step();
    CE = 1'b1;
    beat(2'b10, 1'b1, 4'd0, 8'h00, 8'h01, 1'b0);
    nvec++;
    if ({RES_VALID, ERR, RES} !== {2'b10, 16'h0011}) begin
      nbad++;
      $display("FAIL ce_freeze: got v=%b e=%b res=%h want 1 0 0011",
               RES_VALID, ERR, RES);
    end
  endtask

  task automatic test_reset_mul();
    beat(2'b11, 1'b1, 4'd9, 8'd6, 8'd6, 1'b0);
    RST = 1'b0;
    step();
    RST = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      nvec++;
      if ({RES, RES_VALID, COUT, OFLOW, G, E, L, ERR, BUSY} !== 24'h0) begin
        nbad++;
        $display("FAIL rst_mul_%0d: got res=%h v=%b busy=%b want all 0",
                 i, RES, RES_VALID, BUSY);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add_carry();
    test_split();
    test_timeout();
    test_mul();
    test_ops();
    test_back_to_back();
    test_ce();
    test_reset_mul();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule

// File: doc/alu_pipe_v2.md
Name: alu_pipe_v2

Overview:
- Parametrised next-generation ALU with a split-operand capture handshake, a programmable operand timeout, and a 3-stage pipelined multiplier.
- Width is generic in DW. Rotates are generalised to any power-of-two width.
- All outputs are fully registered with a RES_VALID strobe and a BUSY back-pressure flag.
- Sits between the operand-sourcing datapath and the result bus; one instance per ALU lane.

Parameters:
- DW, 8, operand width; must be a power of two, ≥4.
- CW, 4, command width.
- TIMEOUT, 16, idle cycles allowed between the two operand beats before the held operand is discarded.

Ports:
- CLK  in  1  clock.
- RST  in  1  reset; synchronous, active-low.
- CE  in  1  clock enable; when low, all state and outputs hold.
- MODE  in  1  1 = arithmetic, 0 = logic.
- CMD  in  CW  opcode.
- INP_VALID  in  2  01 = OPA valid, 10 = OPB valid, 11 = both valid, 00 = none.
- OPA  in  DW  operand A.
- OPB  in  DW  operand B.
- CIN  in  1  carry/borrow in.
- RES  out  2*DW  result.
- RES_VALID  out  1  one-cycle strobe; result and flags are valid.
- COUT  out  1  carry out.
- OFLOW  out  1  borrow (unsigned) or overflow (signed).
- G, E, L  out  1 each  compare flags.
- ERR  out  1  illegal command, rotate-range error, or timeout.
- BUSY  out  1  multiplier in flight; INP_VALID is ignored while high.

Behaviour:
- Reset (RST=0 at a CLK edge, regardless of CE):
  - All outputs go to 0.
  - FSM goes to IDLE; counter and captured operands are cleared.
  - Reset mid-multiply kills the operation; no RES_VALID is produced.
- FSM states: IDLE, WAIT_A (B held), WAIT_B (A held), MUL1, MUL2.
  - IDLE: 01 -> capture A, go to WAIT_B. 10 -> capture B, go to WAIT_A. 11 -> capture both, issue.
  - WAIT_B: 10 or 11 -> capture B (and A if 11), issue. 01 -> overwrite A, clear counter.
  - WAIT_A: symmetric to WAIT_B.
  - CMD, MODE and CIN are latched on the completing beat.
- Timeout:
  - In WAIT_x with INP_VALID=00, the counter increments each cycle.
  - When the counter reaches TIMEOUT, on the next edge: RES_VALID=1, ERR=1, RES=0, FSM returns to IDLE.
  - A completing beat on the same edge the counter reaches TIMEOUT wins; no error is raised.
- Issue latency:
  - Non-multiply ops: RES_VALID one cycle after the completing edge. FSM returns to IDLE, so back-to-back 11 beats give one result per cycle.
  - Multiply ops: go to MUL1, then MUL2. RES_VALID is 3 cycles after the completing edge. BUSY is high from the cycle after the completing edge until RES_VALID.
- Flags default to 0 on every RES_VALID unless set by the op. Outputs hold between strobes.
- Arithmetic ops (MODE=1); A and B are unsigned; RES is zero-extended:
  - 0 ADD: RES = A+B in DW+1 bits; COUT = bit DW.
  - 1 SUB: RES = (A-B) mod 2^DW; OFLOW = A<B.
  - 2 ADD_CIN: A+B+CIN; COUT as ADD.
  - 3 SUB_CIN: RES = (A-B-CIN) mod 2^DW; OFLOW = A < B+CIN.
  - 4 INC_A: A+1 in DW+1 bits; 5 DEC_A: (A-1) mod 2^DW.
  - 6 INC_B / 7 DEC_B: same as 4/5 on B.
  - 8 CMP: exactly one of G/E/L set; RES=0.
  - 9 MUL_INC: ((A+1) mod 2^DW) * ((B+1) mod 2^DW), 2*DW bits.
  - 10 MUL_SHL: ((A<<1) mod 2^DW) * B.
  - 11 SADD, 12 SSUB: only with the optional feature.
  - Others: ERR=1, RES=0.
- Logic ops (MODE=0); RES upper DW bits are 0:
  - 0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR, 5 XNOR, 6 NOT_A, 7 NOT_B.
  - 8 SHR_A, 9 SHL_A, 10 SHR_B, 11 SHL_B; all by 1, zero fill.
  - 12 ROL_A_B, 13 ROR_A_B: rotate A by B[SW-1:0], SW = clog2(DW). ERR=1 if any bit of B above SW-1 is set; the rotated result is still returned.
  - 14, 15: ERR=1, RES=0.
- CE low:
  - All state and outputs frozen; counter does not advance; input beats are ignored.
  - A RES_VALID pulse is not re-issued when CE returns high.

Optional Feature:
- Macro: ALU_SIGNED_OPS_EN.
- Defined:
  - CMD 11 SADD: RES = sign-extended signed(A)+signed(B) to 2*DW bits.
  - CMD 12 SSUB: RES = sign-extended signed(A)-signed(B) to 2*DW bits.
  - OFLOW = two's-complement overflow of the DW-bit result.
  - COUT=0.
- Undefined: CMD 11 and 12 are illegal (ERR=1, RES=0).

Decomposition:
- Package alu_pkg:
  - enums arith_cmd_e and logic_cmd_e.
  - FSM state enum.
  - INP_VALID encodings.
  - localparam function for SW.
- Sub-module alu_mul_pipe: registered 2-stage multiplier, DW-parametrised, with a valid-in/valid-out shift.

Test Plan (DW=8, TIMEOUT=16):
- 11, MODE=1, CMD=0, A=0xFF, B=0x01 -> next cycle RES_VALID=1, RES=0x100, COUT=1.
- 01 A=0x05, then 6 cycles idle, then 10 B=0x07 with CMD=1 -> RES=0xFE, OFLOW=1, ERR=0.
- 01 A=0x10, then 16 idle cycles -> RES_VALID=1, ERR=1, RES=0; a following 11 beat is accepted normally.
- 11, CMD=9, A=3, B=4 -> BUSY high for 2 cycles; RES=20 exactly 3 cycles after the beat; a beat issued while BUSY produces no result.
- MODE=0, CMD=12, A=0x81, B=0x11 -> RES=0x03, ERR=1; then B=0x02 -> RES=0x06, ERR=0.
- With ALU_SIGNED_OPS_EN: CMD=11, A=0x7F, B=0x01 -> RES=0x0080, OFLOW=1. RST=0 asserted during MUL1 -> no RES_VALID; all outputs 0.
